// File: rtl/counter_game_gen.sv
// Two-player counter game with IDLE/PLAY/OVER control, scores and game count.
// Define COUNTER_GAME_SAT_EN to saturate main_counter instead of wrapping.
module counter_game_gen #(
  parameter int CNT_W     = 4,
  parameter int STEP_LO   = 1,
  parameter int STEP_HI   = 2,
  parameter int SCORE_W   = 4,
  parameter int WIN_LIMIT = 15,
  parameter int OVER_HOLD = 2
) (
  input  logic               clk,
  input  logic               INIT_n,
  input  logic               load,
  input  logic [CNT_W-1:0]   load_value,
  input  logic               en,
  input  logic [1:0]         control,
  output logic [CNT_W-1:0]   main_counter,
  output logic               WINNER,
  output logic               LOSER,
  output logic [SCORE_W-1:0] winner_count,
  output logic [SCORE_W-1:0] loser_count,
  output logic               GAMEOVER,
  output logic [1:0]         WHO,
  output logic [7:0]         game_num
);

  localparam int HOLD_W = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(OVER_HOLD - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   C_LO      = CNT_W'(STEP_LO);
  localparam logic [CNT_W-1:0]   C_HI      = CNT_W'(STEP_HI);
  localparam logic [SCORE_W-1:0] LIM       = SCORE_W'(WIN_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_win, w_win_nxt;
  logic               r_los, w_los_nxt;
  logic [SCORE_W-1:0] r_wc, w_wc_nxt;
  logic [SCORE_W-1:0] r_lc, w_lc_nxt;
  logic               r_go, w_go_nxt;
  logic [1:0]         r_who, w_who_nxt;
  logic [7:0]         r_gn, w_gn_nxt;
  logic               r_p0, w_p0_nxt;
  logic               r_p1, w_p1_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;

  logic [CNT_W-1:0]   w_step;
  logic [CNT_W-1:0]   w_stepped;
  logic               w_at_zero;
  logic               w_at_max;

  assign w_step    = control[0] ? C_HI : C_LO;
  assign w_at_zero = (r_cnt == '0);
  assign w_at_max  = (r_cnt == CNT_MAX);

`ifdef COUNTER_GAME_SAT_EN
  // One extra bit exposes carry/borrow so the step can clamp.
  logic [CNT_W:0] w_up;
  logic [CNT_W:0] w_dn;
  assign w_up = {1'b0, r_cnt} + {1'b0, w_step};
  assign w_dn = {1'b0, r_cnt} - {1'b0, w_step};
  assign w_stepped = control[1]
    ? (w_dn[CNT_W] ? '0 : w_dn[CNT_W-1:0])
    : (w_up[CNT_W] ? CNT_MAX : w_up[CNT_W-1:0]);
`else
  assign w_stepped = control[1] ? r_cnt - w_step
                                : r_cnt + w_step;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_win_nxt   = 1'b0;
    w_los_nxt   = 1'b0;
    w_wc_nxt    = r_wc;
    w_lc_nxt    = r_lc;
    w_go_nxt    = r_go;
    w_who_nxt   = r_who;
    w_gn_nxt    = r_gn;
    w_p0_nxt    = r_p0;
    w_p1_nxt    = r_p1;
    w_hold_nxt  = r_hold;
    if (load) begin
      w_state_nxt = S_PLAY;
      w_cnt_nxt   = load_value;
      w_wc_nxt    = '0;
      w_lc_nxt    = '0;
      w_go_nxt    = 1'b0;
      w_who_nxt   = 2'b00;
      w_p0_nxt    = 1'b0;
      w_p1_nxt    = 1'b0;
      w_hold_nxt  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_PLAY: begin
          w_win_nxt = w_at_max & ~r_p1;
          w_los_nxt = w_at_zero & ~r_p0;
          w_p0_nxt  = w_at_zero;
          w_p1_nxt  = w_at_max;
          if (w_win_nxt && (r_wc != LIM))
            w_wc_nxt = r_wc + 1'b1;
          if (w_los_nxt && (r_lc != LIM))
            w_lc_nxt = r_lc + 1'b1;
          if (en)
            w_cnt_nxt = w_stepped;
          if (r_wc == LIM) begin
            w_state_nxt = S_OVER;
            w_go_nxt    = 1'b1;
            w_who_nxt   = 2'b10;
            w_hold_nxt  = '0;
          end else if (r_lc == LIM) begin
            w_state_nxt = S_OVER;
            w_go_nxt    = 1'b1;
            w_who_nxt   = 2'b01;
            w_hold_nxt  = '0;
          end
        end
        S_OVER: begin
          if (r_hold == HOLD_LAST) begin
            w_state_nxt = S_PLAY;
            w_wc_nxt    = '0;
            w_lc_nxt    = '0;
            w_go_nxt    = 1'b0;
            w_who_nxt   = 2'b00;
            w_p0_nxt    = 1'b0;
            w_p1_nxt    = 1'b0;
            w_hold_nxt  = '0;
            w_gn_nxt    = r_gn + 8'd1;
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge INIT_n) begin
    if (!INIT_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_win   <= 1'b0;
      r_los   <= 1'b0;
      r_wc    <= '0;
      r_lc    <= '0;
      r_go    <= 1'b0;
      r_who   <= 2'b00;
      r_gn    <= 8'd0;
      r_p0    <= 1'b0;
      r_p1    <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_win   <= w_win_nxt;
      r_los   <= w_los_nxt;
      r_wc    <= w_wc_nxt;
      r_lc    <= w_lc_nxt;
      r_go    <= w_go_nxt;
      r_who   <= w_who_nxt;
      r_gn    <= w_gn_nxt;
      r_p0    <= w_p0_nxt;
      r_p1    <= w_p1_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign main_counter = r_cnt;
  assign WINNER       = r_win;
  assign LOSER        = r_los;
  assign winner_count = r_wc;
  assign loser_count  = r_lc;
  assign GAMEOVER     = r_go;
  assign WHO          = r_who;
  assign game_num     = r_gn;

endmodule

// File: doc/counter_game_gen.md
Name: counter_game_gen

Overview:
- Parametrised successor of the two-player counter game.
- Main counter width, step sizes, win limit and game-over hold time are configurable.
- Adds an explicit IDLE/PLAY/OVER state machine, a count-enable, a synchronous load independent of reset, and a games-played counter.
- Sits between the player control logic and the scoreboard/display logic.

Parameters:
- CNT_W, 4, main counter width (>=2)
- STEP_LO, 1, small step magnitude (1 <= STEP_LO < 2^CNT_W)
- STEP_HI, 2, large step magnitude (STEP_LO <= STEP_HI < 2^CNT_W)
- SCORE_W, 4, width of winner/loser score counters
- WIN_LIMIT, 15, score that ends a game (1..2^SCORE_W-1)
- OVER_HOLD, 2, cycles GAMEOVER stays high (>=1)

Ports:
- clk  in  1  clock, rising edge
- INIT_n  in  1  asynchronous active-low reset
- load  in  1  synchronous start/restart of a game
- load_value  in  CNT_W  counter value applied on load
- en  in  1  count enable
- control  in  2  step select: 00 +STEP_LO, 01 +STEP_HI, 10 -STEP_LO, 11 -STEP_HI
- main_counter  out  CNT_W  game counter
- WINNER  out  1  one-cycle pulse on entry to all-ones
- LOSER  out  1  one-cycle pulse on entry to zero
- winner_count  out  SCORE_W  winner score
- loser_count  out  SCORE_W  loser score
- GAMEOVER  out  1  high while in OVER
- WHO  out  2  00 none, 10 winner side, 01 loser side
- game_num  out  8  completed games, wraps at 255

Behaviour:
- Reset (INIT_n=0, asynchronous):
  - All outputs, prev-flags and hold counter go to 0; state goes to IDLE.
  - Deassertion is released on the next clk edge.
- Priority: reset > load > state logic.
- load=1 in any state:
  - main_counter<=load_value.
  - Scores, WHO, GAMEOVER, pulses and prev-flags cleared.
  - State goes to PLAY; game_num unchanged.
- IDLE: counter holds; no detection; no pulses.
- PLAY with en=1: main_counter updated per control, modulo 2^CNT_W.
- PLAY with en=0: counter holds; detection continues.
- Edge detection (PLAY only), on the registered counter value:
  - If main_counter==0 and prev0==0: LOSER=1 next cycle and loser_count+1.
  - If main_counter==2^CNT_W-1 and prev1==0: WINNER=1 next cycle and winner_count+1.
  - prev0/prev1 track the equality each cycle, so a held value produces exactly one pulse.
  - Latency from counter-value cycle to pulse: 1.
- Scores never exceed WIN_LIMIT; an increment at the limit is suppressed.
- Game end (PLAY):
  - If winner_count==WIN_LIMIT: next cycle state=OVER, GAMEOVER=1, WHO=10.
  - Else if loser_count==WIN_LIMIT: same, with WHO=01.
  - Winner has priority when both are at the limit.
  - Latency from the final pulse to GAMEOVER: 1.
- OVER:
  - Counter frozen; no detection; WINNER and LOSER held 0.
  - Hold counter runs OVER_HOLD cycles.
  - On the last hold cycle: scores, WHO, GAMEOVER and prev-flags cleared; game_num+1; state returns to PLAY.
  - main_counter is retained across the restart.
- load during OVER aborts the hold; game_num is not incremented.
- Reset mid-game: immediate clear; no partial state survives.

Optional Feature:
- Macro: COUNTER_GAME_SAT_EN.
- Defined: main_counter saturates. Up-steps clamp at 2^CNT_W-1 and down-steps clamp at 0; edge detection is unchanged, so a clamped value pulses once.
- Undefined: modulo-2^CNT_W wrap.

Test Plan:
- Reset: drive INIT_n=0 mid-cycle -> all outputs 0 immediately, state IDLE; en=1 in IDLE -> main_counter stays 0, no pulses.
- Wrap case (default params, wrap mode), load with load_value=14, control=00, en=1:
  - load edge: counter 14; next edge: counter 15.
  - Following cycle: WINNER=1, winner_count=1, counter 0.
  - Following cycle: LOSER=1, loser_count=1, counter 1.
- Step skips zero: load 13, control=01 -> counter 13,15,1; exactly one WINNER pulse, no LOSER pulse.
- Held value: counter reaches 15, then en=0 for 10 cycles -> exactly one WINNER pulse, winner_count=1.
- Game over: run until winner_count=15 ->
  - Next cycle GAMEOVER=1, WHO=10, held 2 cycles.
  - Then scores, WHO and GAMEOVER are 0 and game_num=1.
  - Load asserted during OVER instead -> game_num stays 0.
- COUNTER_GAME_SAT_EN defined, load 1, control=11 -> counter 0 and stays 0; exactly one LOSER pulse.
